// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with registered read ports.
// Storage is a flat array of WIDTH-bit entries. Each read port selects one entry and
// registers it. An optional hardwired zero entry and an optional same-edge write-to-read
// bypass are provided.
module regfile_2r1w #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned DEPTH    = 32,
    parameter int          ZERO_REG = 31,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en_a,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    output logic             rd_valid_a,
    input  logic             rd_en_b,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_valid_b
);

    // One extra bit so DEPTH itself is representable when it is a power of two.
    localparam logic [AW:0]   DEPTH_W  = DEPTH[AW:0];
    localparam bit            HAS_ZERO = (ZERO_REG >= 0) && (ZERO_REG < int'(DEPTH));
    localparam logic [AW-1:0] ZERO_IDX = HAS_ZERO ? ZERO_REG[AW-1:0] : '0;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [WIDTH-1:0] rd_data_a_q, rd_data_b_q;
    logic             rd_valid_a_q, rd_valid_b_q;
    logic [WIDTH-1:0] rd_word_a, rd_word_b;
    logic             wr_fire;

    function automatic logic addr_ok(input logic [AW-1:0] addr);
        return ({1'b0, addr} < DEPTH_W);
    endfunction

    function automatic logic is_zero(input logic [AW-1:0] addr);
        return HAS_ZERO && (addr == ZERO_IDX);
    endfunction

    // Writes to the zero entry or past the end of the array are dropped.
    assign wr_fire = wr_en && addr_ok(wr_addr) && !is_zero(wr_addr);

    // Port A selection: zero for the zero entry / out of range, optional bypass.
    always_comb begin
        rd_word_a = '0;
        if (addr_ok(rd_addr_a) && !is_zero(rd_addr_a)) begin
            rd_word_a = mem_q[rd_addr_a];
            // wr_fire already excludes the zero entry and out-of-range addresses.
            if (BYPASS && wr_fire && (wr_addr == rd_addr_a)) begin
                rd_word_a = wr_data;
            end
        end
    end

    // Port B selection: same rules as port A.
    always_comb begin
        rd_word_b = '0;
        if (addr_ok(rd_addr_b) && !is_zero(rd_addr_b)) begin
            rd_word_b = mem_q[rd_addr_b];
            if (BYPASS && wr_fire && (wr_addr == rd_addr_b)) begin
                rd_word_b = wr_data;
            end
        end
    end

    // Storage update: reset clears every entry and dominates any write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_fire) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read output registers: data holds while idle, valid pulses per accepted request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
        end else begin
            rd_valid_a_q <= rd_en_a;
            rd_valid_b_q <= rd_en_b;
            if (rd_en_a) begin
                rd_data_a_q <= rd_word_a;
            end
            if (rd_en_b) begin
                rd_data_b_q <= rd_word_b;
            end
        end
    end

    assign rd_data_a  = rd_data_a_q;
    assign rd_data_b  = rd_data_b_q;
    assign rd_valid_a = rd_valid_a_q;
    assign rd_valid_b = rd_valid_b_q;

endmodule
